// File: rtl/bk_pkg.sv
// ============================================================================
// Module : bk_pkg
// Brief  : Shared types and black-cell helpers for the 16-bit Brent-Kung parts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bk_pkg;

  localparam int WIDTH16 = 16;
  localparam int LVL_UP  = 4;
  localparam int LVL_DN  = 3;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Stage-1 pipeline payload: per-bit terms plus the first two up-sweep levels.
  typedef struct packed {
    logic [WIDTH16-1:0] p_bits;
    logic [WIDTH16-1:0] g_bits;
    gp_t  [7:0]         l0;
    gp_t  [3:0]         l1;
    logic               a15;
    logic               b15;
  } s1_t;

  function automatic gp_t black_f(input logic ghi, input logic phi,
                                  input logic glo, input logic plo);
    gp_t r;
    r.g = ghi | (phi & glo);
    r.p = phi & plo;
    return r;
  endfunction

  function automatic gp_t black_gp(input gp_t hi, input gp_t lo);
    return black_f(hi.g, hi.p, lo.g, lo.p);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bk16_sub_prefix_hi.sv
// ============================================================================
// Module : bk16_sub_prefix_hi
// Brief  : Stage-2 completion of the BK tree (levels 2-3 and down-sweep) to carries.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bk16_sub_prefix_hi
  import bk_pkg::*;
(
  input  logic [WIDTH16-1:0] g_bits,
  input  logic [WIDTH16-1:0] p_bits,
  input  gp_t  [7:0]         l0,
  input  gp_t  [3:0]         l1,
  output logic [WIDTH16-1:0] carry,
  output logic               cout
);

  gp_t  [1:0]         w_l2;
  gp_t  [WIDTH16-1:0] w_pre;   // w_pre[i] = group (g,p) over bits i..0, carry-in folded
  logic [WIDTH16-1:0] w_pre_p;
  logic               unused_ok;

  always_comb begin
    w_l2     = '0;
    w_pre    = '0;
    w_l2[0]  = black_gp(l1[1], l1[0]);
    w_l2[1]  = black_gp(l1[3], l1[2]);
    w_pre[0] = '{g: g_bits[0], p: p_bits[0]};
    w_pre[1] = l0[0];
    w_pre[3] = l1[0];
    w_pre[7] = w_l2[0];
    w_pre[15] = black_gp(w_l2[1], w_pre[7]);
    w_pre[11] = black_gp(l1[2], w_pre[7]);
    w_pre[5]  = black_gp(l0[2], w_pre[3]);
    w_pre[9]  = black_gp(l0[4], w_pre[7]);
    w_pre[13] = black_gp(l0[6], w_pre[11]);
    // Final down-sweep row: every even bit joins the odd prefix just below it.
    for (int i = 1; i < 8; i++) begin
      w_pre[2*i] = black_gp('{g: g_bits[2*i], p: p_bits[2*i]}, w_pre[2*i-1]);
    end
  end

  always_comb begin
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 1; i < WIDTH16; i++) begin
      carry[i] = w_pre[i-1].g;
    end
  end

  assign cout = w_pre[15].g;

  always_comb begin
    w_pre_p = '0;
    for (int i = 0; i < WIDTH16; i++) begin
      w_pre_p[i] = w_pre[i].p;
    end
  end

  // Odd per-bit g and odd level-0 cells were consumed by stage 1 already.
  assign unused_ok = ^{w_pre_p, g_bits[15], g_bits[13], g_bits[11], g_bits[9],
                       g_bits[7], g_bits[5], g_bits[3], g_bits[1],
                       l0[7], l0[5], l0[3], l0[1]};

endmodule

`default_nettype wire

// File: rtl/bk16_sub_pipe.sv
// ============================================================================
// Module : bk16_sub_pipe
// Brief  : Two-stage 16-bit Brent-Kung subtractor with compare flags and valid/ready.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bk16_sub_pipe
  import bk_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit FLAGS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output logic             lt_s
);

  logic               w_adv2;
  logic [WIDTH16-1:0] w_bb;
  s1_t                w_s1_next;
  s1_t                r_s1;
  logic               r_s1_valid;
  logic               r_s2_valid;
  logic [WIDTH16-1:0] r_diff;
  logic [WIDTH16-1:0] w_carry;
  logic [WIDTH16-1:0] w_diff;
  logic               w_cout;

  assign w_adv2    = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_adv2;
  assign out_valid = r_s2_valid;
  assign diff      = r_diff;

  // Stage 1: per-bit terms with carry-in folded into g[0], then levels 0 and 1.
  always_comb begin
    w_s1_next           = '0;
    w_bb                = ~b;
    w_s1_next.p_bits    = a ^ w_bb;
    w_s1_next.g_bits    = a & w_bb;
    w_s1_next.g_bits[0] = a[0] | w_bb[0];
    for (int j = 0; j < 8; j++) begin
      w_s1_next.l0[j] = black_f(w_s1_next.g_bits[2*j+1], w_s1_next.p_bits[2*j+1],
                                w_s1_next.g_bits[2*j],   w_s1_next.p_bits[2*j]);
    end
    for (int k = 0; k < 4; k++) begin
      w_s1_next.l1[k] = black_gp(w_s1_next.l0[2*k+1], w_s1_next.l0[2*k]);
    end
    w_s1_next.a15 = a[15];
    w_s1_next.b15 = b[15];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1 <= w_s1_next;
    end
  end

  bk16_sub_prefix_hi u_prefix_hi (
    .g_bits (r_s1.g_bits),
    .p_bits (r_s1.p_bits),
    .l0     (r_s1.l0),
    .l1     (r_s1.l1),
    .carry  (w_carry),
    .cout   (w_cout)
  );

  assign w_diff = r_s1.p_bits ^ w_carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_diff     <= '0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_diff <= w_diff;
    end
  end

  generate
    if (FLAGS_EN) begin : g_flags
      logic w_ovf;
      logic r_borrow, r_ovf, r_zero, r_lt_s;

      assign w_ovf = (r_s1.a15 ^ r_s1.b15) & (r_s1.a15 ^ w_diff[15]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_borrow <= 1'b0;
          r_ovf    <= 1'b0;
          r_zero   <= 1'b0;
          r_lt_s   <= 1'b0;
        end else if (w_adv2 && r_s1_valid) begin
          r_borrow <= ~w_cout;
          r_ovf    <= w_ovf;
          r_zero   <= ~|w_diff;
          r_lt_s   <= w_diff[15] ^ w_ovf;
        end
      end

      assign borrow = r_borrow;
      assign ovf    = r_ovf;
      assign zero   = r_zero;
      assign lt_s   = r_lt_s;
    end else begin : g_no_flags
      assign borrow = 1'b0;
      assign ovf    = 1'b0;
      assign zero   = 1'b0;
      assign lt_s   = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/bk16_sub_pipe.md
Name: bk16_sub_pipe

Overview:
- 16-bit two's-complement subtractor, D = A - B, built on a Brent-Kung prefix network of black cells.
- Split into two pipeline stages behind a valid/ready handshake.
- Produces the difference plus compare flags: borrow, signed overflow, zero, signed-less-than.
- Sits beside the 16-bit BK adder in the datapath library and feeds comparators and address-decrement paths that need registered, back-pressurable results.

Parameters:
- WIDTH, 16, operand width; only 16 is supported, and the prefix tree is hard-wired for 16.
- FLAGS_EN, 1, when 0 the flag outputs are tied to 0 and their registers are removed.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands A and B are presented
- in_ready  out  1  stage 1 can accept this cycle
- a  in  16  minuend
- b  in  16  subtrahend
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts the result this cycle
- diff  out  16  A - B mod 2^16
- borrow  out  1  1 when A < B unsigned (the inverse of the carry-out)
- ovf  out  1  signed overflow
- zero  out  1  diff == 0
- lt_s  out  1  A < B signed (diff[15] ^ ovf)

Behaviour:
- Reset (asynchronous, rst_n=0):
  - s1_valid=0, s2_valid=0, so out_valid=0 and in_ready=1.
  - diff, borrow, ovf, zero and lt_s reset to 0.
  - Any in-flight operands are discarded.
  - After rst_n deasserts, the block accepts on the first rising edge where in_valid=1.
- Preprocess (stage 1, combinational):
  - bb = ~b.
  - G[i] = a[i] & bb[i], P[i] = a[i] ^ bb[i].
  - Carry-in is 1. It is folded into bit 0: G[0] = a[0] | bb[0], and the P[0] used for the sum is kept separately.
- Stage 1 logic:
  - Computes prefix levels 0 and 1: 2-bit and 4-bit group g/p, same pairing as the BK up-sweep.
  - Registers the following into stage-1 registers: per-bit P (16), per-bit G (16), level-0 g/p (8 each), level-1 g/p (4 each), a[15], b[15].
- Stage 2 logic:
  - Completes the up-sweep (levels 2, 3) and the down-sweep (intermediate and final black cells), giving carries c[15:0] into each bit.
  - c[0] = 1.
  - diff[i] = P[i] ^ c[i].
  - cout = prefix G over bits 15..0 including carry-in.
  - borrow = ~cout.
  - ovf = (a15 ^ b15) & (a15 ^ diff[15]).
  - zero = ~|diff.
  - lt_s = diff[15] ^ ovf.
  - All results and flags are registered at the output.
- Latency: exactly 2 cycles from acceptance (in_valid & in_ready) to out_valid when unstalled.
- Throughput: 1 result per cycle.
- Handshake:
  - adv2 = ~s2_valid | out_ready.
  - in_ready = ~s1_valid | adv2.
  - Stage 2 loads when adv2; s2_valid_next = s1_valid.
  - Stage 1 loads when in_ready; s1_valid_next = in_valid.
  - in_ready does not depend combinationally on in_valid.
- Stall: out_valid=1 & out_ready=0 holds diff and all flags stable. With both stages full, in_ready=0 and stage-1 contents are held.
- Simultaneous accept and drain with a full pipe: no bubble, no loss, no duplication.
- Backpressure released after a stall: the held result is transferred first, then the stage-1 result on the next cycle.
- Outputs carry no X after reset, even when out_valid=0.
- a and b are sampled only on acceptance; changes while in_ready=0 are ignored.

Decomposition:
- Shared package bk_pkg, holding:
  - WIDTH16 = 16.
  - Level counts LVL_UP = 4, LVL_DN = 3.
  - Typedef gp_t (g, p pair).
  - Function black_f(ghi, phi, glo, plo) -> {ghi | phi&glo, phi&plo}, which mirrors the existing black cell.
- One sub-module, bk16_sub_prefix_hi: stage-2 combinational completion of the tree, from the registered stage-1 group terms to carries. It reuses the existing black cell instances.
- Handshake and registers stay in the top.

Test Plan:
- Reset, then a=0x0005, b=0x0003, out_ready=1:
  - out_valid rises 2 cycles after acceptance.
  - diff=0x0002, borrow=0, ovf=0, zero=0, lt_s=0.
- a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, ovf=0, lt_s=1, zero=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, lt_s=1, borrow=0.
- a=0x1234, b=0x1234 -> diff=0x0000, zero=1, borrow=0.
- a=0x0000, b=0xFFFF -> diff=0x0001, borrow=1, lt_s=0.
- Streaming with backpressure:
  - Stimulus: 10 back-to-back operand pairs (including 0x7FFF-0xFFFF and 0xFFFF-0x0000), out_ready toggled in a 1-0-0-1 pattern, rst_n pulsed low mid-stream once.
  - Required: results arrive in order, match (a-b) mod 2^16 and the flag reference, and are stable during stalls.
  - Required: in_ready=0 only when both stages are full and out_ready=0.
  - Required: after the reset pulse, out_valid=0 immediately and no pre-reset result appears afterwards.
